// File: rtl/abh_wide.sv
// abh_wide: high-byte address unit for the 65C02 microcoded datapath.
// Forms the next high address (ADH) from a selected base plus a small
// carry-corrected offset, registers it as ABH, and keeps PCH and TMP.
// With PAGE_FIX set, a page-crossing carry/borrow is deferred into one
// extra cycle (6502-style) instead of being applied combinationally.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | normal address formation; may defer a page crossing
// S_FIX_INC | one-cycle fix: ABH <= ABH + 1 (carry out of low byte)
// S_FIX_DEC | one-cycle fix: ABH <= ABH - 1 (borrow out of low byte)
module abh_wide #(
  parameter int             W          = 8,
  parameter bit             PAGE_FIX   = 1'b1,
  parameter logic [W-1:0]   STACK_PAGE = W'('h01)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  input  logic         CI,
  input  logic [W-1:0] DB,
  input  logic [4:0]   op,
  input  logic         fix_en,
  input  logic         ld_pc,
  input  logic         inc_pc,
  input  logic         ld_tmp,
  output logic [W-1:0] ADH,
  output logic [W-1:0] ABH,
  output logic [W-1:0] PCH,
  output logic         CO,
  output logic         fix_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FIX_INC = 2'd1,
    S_FIX_DEC = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ONES = '1;

  state_t       state, state_nxt;
  logic [W-1:0] abh_q, pch_q, tmp_q;
  logic [W-1:0] base, offset;
  logic [W:0]   sum;
  logic         defer_inc, defer_dec;

  // Base operand selected by op[4:2]; TMP as base always sees the old value.
  always_comb begin
    base = '0;
    case (op[4:2])
      3'b001:  base = abh_q;
      3'b010:  base = pch_q;
      3'b011:  base = DB;
      3'b100:  base = STACK_PAGE;
      3'b101:  base = tmp_q;
      default: base = '0;
    endcase
  end

  // Offset selected by op[1:0]; mode 11 is "-1 + CI", i.e. all-ones or zero.
  always_comb begin
    offset = '0;
    case (op[1:0])
      2'b00: offset = '0;
      2'b01: offset = ONE;
      2'b10: offset = {{(W-1){1'b0}}, CI};
      2'b11: offset = CI ? '0 : ONES;
    endcase
  end

  // Adder and next-state: FIX states override the operands, and a deferred
  // crossing passes the uncorrected base through with no carry out.
  always_comb begin
    defer_inc = PAGE_FIX && fix_en && (op[1:0] == 2'b10) && CI;
    defer_dec = PAGE_FIX && fix_en && (op[1:0] == 2'b11) && !CI;
    sum       = {1'b0, base} + {1'b0, offset};
    state_nxt = S_IDLE;
    case (state)
      S_FIX_INC: sum = {1'b0, abh_q} + {1'b0, ONE};
      S_FIX_DEC: sum = {1'b0, abh_q} + {1'b0, ONES};
      default: begin
        if (defer_inc) begin
          sum       = {1'b0, base};
          state_nxt = S_FIX_INC;
        end else if (defer_dec) begin
          sum       = {1'b0, base};
          state_nxt = S_FIX_DEC;
        end
      end
    endcase
  end

  // State and datapath registers; rdy low freezes everything, FIX included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      abh_q <= '0;
      pch_q <= '0;
      tmp_q <= '0;
    end else if (rdy) begin
      state <= state_nxt;
      abh_q <= sum[W-1:0];
      if (ld_pc)  pch_q <= abh_q + {{(W-1){1'b0}}, inc_pc};
      if (ld_tmp) tmp_q <= DB;
    end
  end

  assign ADH      = sum[W-1:0];
  assign CO       = sum[W];
  assign ABH      = abh_q;
  assign PCH      = pch_q;
  assign fix_busy = (state != S_IDLE);

endmodule

// File: tb/tb_abh_wide.sv
// Bench for abh_wide: three instances (8-bit with page fix, 8-bit without,
// 16-bit with page fix). Stimulus pushes expected values into a queue and a
// separate monitor pops and compares them while the outputs are settled.
module tb_abh_wide;

  logic        clk = 1'b0;
  logic        rst_n, rdy, ci, fe, ld_pc, inc_pc, ld_tmp;
  logic [4:0]  op;
  logic [7:0]  db8;
  logic [15:0] db16;

  logic [7:0]  adh8, abh8, pch8, adhn, abhn, pchn;
  logic        co8, busy8, con, busyn;
  logic [15:0] adh16, abh16, pch16;
  logic        co16, busy16;

  always #5 clk = ~clk;

  abh_wide #(.W(8), .PAGE_FIX(1'b1), .STACK_PAGE(8'h01)) u8 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .CI(ci), .DB(db8), .op(op),
    .fix_en(fe), .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_tmp(ld_tmp),
    .ADH(adh8), .ABH(abh8), .PCH(pch8), .CO(co8), .fix_busy(busy8));

  abh_wide #(.W(8), .PAGE_FIX(1'b0), .STACK_PAGE(8'h01)) u8n (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .CI(ci), .DB(db8), .op(op),
    .fix_en(fe), .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_tmp(ld_tmp),
    .ADH(adhn), .ABH(abhn), .PCH(pchn), .CO(con), .fix_busy(busyn));

  abh_wide #(.W(16), .PAGE_FIX(1'b1), .STACK_PAGE(16'h0001)) u16 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .CI(ci), .DB(db16), .op(op),
    .fix_en(fe), .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_tmp(ld_tmp),
    .ADH(adh16), .ABH(abh16), .PCH(pch16), .CO(co16), .fix_busy(busy16));

  localparam int ADH8 = 0, CO8 = 1, ABH8 = 2, PCH8 = 3, BUSY8 = 4;
  localparam int ADHN = 5, ABHN = 6, BUSYN = 7;
  localparam int ADH16 = 8, CO16 = 9, ABH16 = 10, PCH16 = 11, BUSY16 = 12;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] v;
  } chk_t;

  chk_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic ex(input string nm, input int sel, input logic [15:0] v);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.v    = v;
    q.push_back(c);
  endtask

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      ADH8:    return {8'h00, adh8};
      CO8:     return {15'd0, co8};
      ABH8:    return {8'h00, abh8};
      PCH8:    return {8'h00, pch8};
      BUSY8:   return {15'd0, busy8};
      ADHN:    return {8'h00, adhn};
      ABHN:    return {8'h00, abhn};
      BUSYN:   return {15'd0, busyn};
      ADH16:   return adh16;
      CO16:    return {15'd0, co16};
      ABH16:   return abh16;
      PCH16:   return pch16;
      BUSY16:  return {15'd0, busy16};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: drains pending expectations every time unit.
  initial begin
    forever begin
      #1;
      while (q.size() != 0) begin
        chk_t c;
        logic [15:0] a;
        c = q.pop_front();
        a = actual(c.sel);
        n_vec++;
        if (a !== c.v) begin
          n_miss++;
          $display("FAIL %s: got %h, expected %h (t=%0t)", c.name, a, c.v, $time);
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    op = 5'b0; ci = 1'b0; fe = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0;
    ld_tmp = 1'b0; rdy = 1'b1; db8 = 8'h00; db16 = 16'h0000;
  endtask

  // Reference model for the 16-bit instance.
  logic [15:0] m_abh, m_pch, m_tmp, n_abh, n_pch, n_tmp;
  int          m_st, n_st;

  task automatic model_eval(output logic [15:0] adh, output logic co, output int nst);
    logic [16:0] s;
    logic [15:0] b, o;
    nst = 0;
    b = 16'h0000;
    o = 16'h0000;
    if (m_st == 1) s = {1'b0, m_abh} + 17'd1;
    else if (m_st == 2) s = {1'b0, m_abh} + 17'h0FFFF;
    else begin
      case (op[4:2])
        3'd1: b = m_abh;
        3'd2: b = m_pch;
        3'd3: b = db16;
        3'd4: b = 16'h0001;
        3'd5: b = m_tmp;
        default: b = 16'h0000;
      endcase
      case (op[1:0])
        2'd0: o = 16'h0000;
        2'd1: o = 16'h0001;
        2'd2: o = ci ? 16'h0001 : 16'h0000;
        default: o = ci ? 16'h0000 : 16'hFFFF;
      endcase
      s = {1'b0, b} + {1'b0, o};
      if (fe && ((op[1:0] == 2'd2 && ci) || (op[1:0] == 2'd3 && !ci))) begin
        s   = {1'b0, b};
        nst = (op[1:0] == 2'd2) ? 1 : 2;
      end
    end
    adh = s[15:0];
    co  = s[16];
  endtask

  initial begin
    logic [15:0] e_adh;
    logic        e_co;
    int          e_nst;
    bit          do_rst;

    rst_n = 1'b0;
    op = 5'b0; ci = 1'b0; fe = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0;
    ld_tmp = 1'b0; rdy = 1'b1; db8 = 8'h00; db16 = 16'h0000;

    nxt(); #1;
    ex("rst_abh", ABH8, 16'h00); ex("rst_pch", PCH8, 16'h00); ex("rst_busy", BUSY8, 16'h0);
    #2 rst_n = 1'b1;

    // Offset modes
    nxt(); db8 = 8'h7F; op = 5'b011_10; ci = 1'b1; #1;
    ex("ci_add_adh", ADH8, 16'h80); ex("ci_add_co", CO8, 16'h0);
    nxt(); db8 = 8'hFF; op = 5'b011_01; #1;
    ex("abh_80", ABH8, 16'h80); ex("inc_wrap_adh", ADH8, 16'h00); ex("inc_wrap_co", CO8, 16'h1);
    nxt(); op = 5'b001_11; #1;
    ex("abh_00", ABH8, 16'h00); ex("dec_adh", ADH8, 16'hFF); ex("dec_co", CO8, 16'h0);

    // PC load with and without increment
    nxt(); op = 5'b001_00; ld_pc = 1'b1; #1;
    ex("abh_ff", ABH8, 16'hFF);
    nxt(); ld_pc = 1'b1; inc_pc = 1'b1; #1;
    ex("pch_ff", PCH8, 16'hFF);
    nxt(); ld_tmp = 1'b1; db8 = 8'hA5; op = 5'b101_01; #1;
    ex("pch_inc_wrap", PCH8, 16'h00); ex("abh_00b", ABH8, 16'h00); ex("tmp_old", ADH8, 16'h01);
    nxt(); op = 5'b101_01; #1;
    ex("tmp_adh", ADH8, 16'hA6); ex("tmp_co", CO8, 16'h0);
    nxt(); op = 5'b100_00; #1;
    ex("stack_adh", ADH8, 16'h01);

    // Page fix, increment
    nxt(); db8 = 8'h12; op = 5'b011_10; ci = 1'b1; fe = 1'b1; #1;
    ex("abh_01", ABH8, 16'h01); ex("pfi_adh", ADH8, 16'h12); ex("pfi_co", CO8, 16'h0);
    ex("pfi_busy0", BUSY8, 16'h0); ex("nofix_adh", ADHN, 16'h13); ex("nofix_busy", BUSYN, 16'h0);
    nxt(); op = 5'b011_01; fe = 1'b1; ld_pc = 1'b1; #1;
    ex("pfi_abh", ABH8, 16'h12); ex("pfi_busy1", BUSY8, 16'h1); ex("pfi_adh13", ADH8, 16'h13);
    ex("nofix_abh", ABHN, 16'h13); ex("nofix_busy1", BUSYN, 16'h0);
    nxt(); db8 = 8'h12; op = 5'b011_10; fe = 1'b1; #1;
    ex("pfi_done_abh", ABH8, 16'h13); ex("pfi_done_busy", BUSY8, 16'h0);
    ex("pch_in_fix", PCH8, 16'h12); ex("noncross_adh", ADH8, 16'h12);
    nxt(); db8 = 8'h40; op = 5'b011_11; fe = 1'b1; #1;
    ex("noncross_abh", ABH8, 16'h12); ex("noncross_busy", BUSY8, 16'h0);
    ex("pfd_adh", ADH8, 16'h40); ex("pfd_co", CO8, 16'h0);

    // Page fix, decrement with a 3-cycle stall
    nxt(); rdy = 1'b0; #1;
    ex("pfd_abh", ABH8, 16'h40); ex("pfd_busy", BUSY8, 16'h1); ex("pfd_adh3f", ADH8, 16'h3F);
    for (int k = 0; k < 3; k++) begin
      nxt(); rdy = (k == 2); #1;
      ex("stall_abh", ABH8, 16'h40); ex("stall_busy", BUSY8, 16'h1); ex("stall_adh", ADH8, 16'h3F);
    end
    nxt(); db8 = 8'h12; op = 5'b011_10; ci = 1'b1; fe = 1'b1; #1;
    ex("pfd_done_abh", ABH8, 16'h3F); ex("pfd_done_busy", BUSY8, 16'h0);

    // Async reset in the middle of a fix
    nxt(); op = 5'b101_00; #1;
    ex("prerst_busy", BUSY8, 16'h1); ex("prerst_abh", ABH8, 16'h12);
    #2 rst_n = 1'b0;
    #1;
    ex("midrst_abh", ABH8, 16'h00); ex("midrst_pch", PCH8, 16'h00);
    ex("midrst_busy", BUSY8, 16'h0); ex("midrst_tmp", ADH8, 16'h00);
    #2 rst_n = 1'b1;
    nxt(); op = 5'b000_01; #1;
    ex("postrst_busy", BUSY8, 16'h0); ex("postrst_abh", ABH8, 16'h00); ex("postrst_adh", ADH8, 16'h01);
    nxt(); #1;
    ex("postrst_idle", ABH8, 16'h01); ex("postrst_busy2", BUSY8, 16'h0);

    // 16-bit width
    nxt(); db16 = 16'hFFFF; op = 5'b011_00; #1;
    ex("w16_adh", ADH16, 16'hFFFF);
    nxt(); ld_pc = 1'b1; #1;
    ex("w16_abh", ABH16, 16'hFFFF);
    nxt(); op = 5'b010_01; #1;
    ex("w16_pch", PCH16, 16'hFFFF); ex("w16_wrap_adh", ADH16, 16'h0000); ex("w16_wrap_co", CO16, 16'h1);

    // Random sequences on the 16-bit instance against the model
    m_abh = 16'h0; m_pch = 16'h0; m_tmp = 16'h0; m_st = 0;
    n_abh = 16'h0; n_pch = 16'h0; n_tmp = 16'h0; n_st = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      m_abh = n_abh; m_pch = n_pch; m_tmp = n_tmp; m_st = n_st;
      do_rst = (i == 0) || ($urandom_range(0, 39) == 0);
      op     = 5'($urandom_range(0, 31));
      ci     = 1'($urandom_range(0, 1));
      fe     = 1'($urandom_range(0, 1));
      ld_pc  = ($urandom_range(0, 3) == 0);
      inc_pc = 1'($urandom_range(0, 1));
      ld_tmp = ($urandom_range(0, 3) == 0);
      rdy    = ($urandom_range(0, 3) != 0);
      db16   = 16'($urandom);
      db8    = 8'h00;
      if (do_rst) begin
        rst_n = 1'b0;
        m_abh = 16'h0; m_pch = 16'h0; m_tmp = 16'h0; m_st = 0;
      end
      #1;
      model_eval(e_adh, e_co, e_nst);
      ex("rnd_adh", ADH16, e_adh);
      if (m_st == 0) ex("rnd_co", CO16, {15'd0, e_co});
      ex("rnd_abh", ABH16, m_abh);
      ex("rnd_pch", PCH16, m_pch);
      ex("rnd_busy", BUSY16, (m_st != 0) ? 16'h1 : 16'h0);
      n_abh = m_abh; n_pch = m_pch; n_tmp = m_tmp; n_st = m_st;
      if (rdy) begin
        n_abh = e_adh;
        if (ld_pc)  n_pch = m_abh + (inc_pc ? 16'h1 : 16'h0);
        if (ld_tmp) n_tmp = db16;
        n_st = e_nst;
      end
      if (do_rst) begin
        #2 rst_n = 1'b1;
      end
    end

    nxt(); nxt();
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending checks, expected 0", q.size());
      n_miss += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
